// File: rtl/rx_trainerror_resp.sv
// rtl/rx_trainerror_resp.sv - RX-side TRAINERROR handshake responder
// Answers a partner entry_req with entry_resp once; the same counter times both the wait and the send.
module rx_trainerror_resp #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_trainerror_en,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_tx_valid,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
  output logic                    o_valid_rx,
  output logic                    o_trainerror_end_rx,
  output logic                    o_timeout_rx
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [SB_MSG_WIDTH-1:0] MSG_ENTRY_REQ  = SB_MSG_WIDTH'(15);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_ENTRY_RESP = SB_MSG_WIDTH'(14);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_REQ  = 3'd1,
    ST_SEND_RESP = 3'd2,
    ST_DONE      = 3'd3,
    ST_TIMEOUT   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic req_seen;
  logic resp_sent;
  logic cnt_expired;
  logic [CNT_W-1:0] cnt_next;

  assign req_seen    = i_rx_msg_valid && (i_decoded_SB_msg == MSG_ENTRY_REQ);
  // A busy falling edge while TX is requesting belongs to the TX transfer, not ours.
  assign resp_sent   = i_falling_edge_busy && !i_tx_valid;
  assign cnt_expired = (cnt == CNT_LAST);
  assign cnt_next    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= ST_IDLE;
      cnt                 <= '0;
      o_encoded_SB_msg_rx <= '0;
      o_valid_rx          <= 1'b0;
      o_trainerror_end_rx <= 1'b0;
      o_timeout_rx        <= 1'b0;
    end else if (!i_trainerror_en) begin
      state               <= ST_IDLE;
      cnt                 <= '0;
      o_encoded_SB_msg_rx <= '0;
      o_valid_rx          <= 1'b0;
      o_trainerror_end_rx <= 1'b0;
      o_timeout_rx        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (req_seen) begin
            state               <= ST_SEND_RESP;
            o_encoded_SB_msg_rx <= MSG_ENTRY_RESP;
            o_valid_rx          <= 1'b1;
          end else begin
            state <= ST_WAIT_REQ;
          end
        end
        ST_WAIT_REQ: begin
          if (cnt_expired) begin
            state        <= ST_TIMEOUT;
            o_timeout_rx <= 1'b1;
          end else begin
            cnt <= cnt_next;
            if (req_seen) begin
              state               <= ST_SEND_RESP;
              o_encoded_SB_msg_rx <= MSG_ENTRY_RESP;
              o_valid_rx          <= 1'b1;
            end
          end
        end
        ST_SEND_RESP: begin
          // Completion is checked first so it wins over a simultaneous expiry.
          if (resp_sent) begin
            state               <= ST_DONE;
            o_encoded_SB_msg_rx <= '0;
            o_valid_rx          <= 1'b0;
            o_trainerror_end_rx <= 1'b1;
          end else if (cnt_expired) begin
            state               <= ST_TIMEOUT;
            o_encoded_SB_msg_rx <= '0;
            o_valid_rx          <= 1'b0;
            o_timeout_rx        <= 1'b1;
          end else begin
            cnt <= cnt_next;
          end
        end
        ST_DONE, ST_TIMEOUT: begin
          state <= state;
        end
        default: begin
          state               <= ST_IDLE;
          cnt                 <= '0;
          o_encoded_SB_msg_rx <= '0;
          o_valid_rx          <= 1'b0;
          o_trainerror_end_rx <= 1'b0;
          o_timeout_rx        <= 1'b0;
        end
      endcase
    end
  end

endmodule
